// File: rtl/sensor_packet_scheduler.sv
// sensor_packet_scheduler
// Stages BNO085 quaternion and gyro samples, merges them within a bounded
// collection window, and commits a frozen snapshot that drives the sensor-data
// inputs of mcu_spi_slave for the whole SPI readout.
// Optional feature macro: PKT_SEQ_EN adds a 4-bit acknowledge sequence number
// in pkt_flags[7:4]. When it is undefined, pkt_flags[7:2] is always zero.
// Handshake: done rises in the cycle after a commit. It stays high until a
// synchronized rising edge of load or until the acknowledge timeout expires.
// pkt_* and pkt_flags change only in the commit cycle, while done is low.
// The FSM state is exported on the state port.
module sensor_packet_scheduler #(
    parameter int COLLECT_WIN = 64,
    parameter int ACK_TIMEOUT = 3_000_000,
    parameter int HOLDOFF_CYC = 300
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               quat_valid,
    input  logic signed [15:0] quat_w,
    input  logic signed [15:0] quat_x,
    input  logic signed [15:0] quat_y,
    input  logic signed [15:0] quat_z,
    input  logic               gyro_valid,
    input  logic signed [15:0] gyro_x,
    input  logic signed [15:0] gyro_y,
    input  logic signed [15:0] gyro_z,
    input  logic               load,
    output logic               done,
    output logic signed [15:0] pkt_quat_w,
    output logic signed [15:0] pkt_quat_x,
    output logic signed [15:0] pkt_quat_y,
    output logic signed [15:0] pkt_quat_z,
    output logic signed [15:0] pkt_gyro_x,
    output logic signed [15:0] pkt_gyro_y,
    output logic signed [15:0] pkt_gyro_z,
    output logic [7:0]         pkt_flags,
    output logic [7:0]         drop_cnt,
    output logic [1:0]         state
);

    localparam int WIN_W = $clog2(COLLECT_WIN);
    localparam int HO_W  = $clog2(HOLDOFF_CYC + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(COLLECT_WIN - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYC - 1);
    localparam logic [23:0]      TO_LAST  = 24'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2,
        S_HOLDOFF = 2'd3
    } state_t;

    state_t st;

    logic load_s1, load_s2, load_s2_d;
    logic load_rise;

    logic signed [15:0] stg_qw, stg_qx, stg_qy, stg_qz;
    logic signed [15:0] stg_gx, stg_gy, stg_gz;
    logic q_seen, g_seen;

    logic [WIN_W-1:0] win_cnt;
    logic [23:0]      to_cnt;
    logic [HO_W-1:0]  ho_cnt;
    logic [3:0]       seq_bits;

    assign state     = st;
    assign load_rise = load_s2 & ~load_s2_d;

    // Two-flop synchronizer for the asynchronous MCU acknowledge, plus one delay stage for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_s1   <= 1'b0;
            load_s2   <= 1'b0;
            load_s2_d <= 1'b0;
        end else begin
            load_s1   <= load;
            load_s2   <= load_s1;
            load_s2_d <= load_s2;
        end
    end

`ifdef PKT_SEQ_EN
    logic [3:0] seq_cnt;

    // Sequence number advances only on an acknowledge, so a dropped packet shows up as a repeated number.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt <= 4'd0;
        end else if (st == S_PRESENT && load_rise) begin
            seq_cnt <= seq_cnt + 4'd1;
        end
    end

    assign seq_bits = seq_cnt;
`else
    assign seq_bits = 4'd0;
`endif

    // Packet FSM with staging capture, commit snapshot, ack/timeout handling and holdoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= S_IDLE;
            done       <= 1'b0;
            stg_qw     <= '0;
            stg_qx     <= '0;
            stg_qy     <= '0;
            stg_qz     <= '0;
            stg_gx     <= '0;
            stg_gy     <= '0;
            stg_gz     <= '0;
            q_seen     <= 1'b0;
            g_seen     <= 1'b0;
            pkt_quat_w <= '0;
            pkt_quat_x <= '0;
            pkt_quat_y <= '0;
            pkt_quat_z <= '0;
            pkt_gyro_x <= '0;
            pkt_gyro_y <= '0;
            pkt_gyro_z <= '0;
            pkt_flags  <= 8'd0;
            drop_cnt   <= 8'd0;
            win_cnt    <= '0;
            to_cnt     <= '0;
            ho_cnt     <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (quat_valid || gyro_valid) begin
                        win_cnt <= '0;
                        st      <= S_COLLECT;
                    end
                end
                S_COLLECT: begin
                    if ((q_seen && g_seen) || (win_cnt == WIN_LAST)) begin
                        // An absent sensor leaves its snapshot fields untouched.
                        if (q_seen) begin
                            pkt_quat_w <= stg_qw;
                            pkt_quat_x <= stg_qx;
                            pkt_quat_y <= stg_qy;
                            pkt_quat_z <= stg_qz;
                        end
                        if (g_seen) begin
                            pkt_gyro_x <= stg_gx;
                            pkt_gyro_y <= stg_gy;
                            pkt_gyro_z <= stg_gz;
                        end
                        pkt_flags <= {seq_bits, 2'b00, g_seen, q_seen};
                        q_seen    <= 1'b0;
                        g_seen    <= 1'b0;
                        done      <= 1'b1;
                        to_cnt    <= '0;
                        st        <= S_PRESENT;
                    end else begin
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                S_PRESENT: begin
                    if (load_rise) begin
                        // An ack in the same cycle as the timeout counts as an ack.
                        done   <= 1'b0;
                        ho_cnt <= '0;
                        st     <= S_HOLDOFF;
                    end else if (to_cnt == TO_LAST) begin
                        done   <= 1'b0;
                        ho_cnt <= '0;
                        st     <= S_HOLDOFF;
                        if (drop_cnt != 8'hFF) begin
                            drop_cnt <= drop_cnt + 8'd1;
                        end
                    end else begin
                        to_cnt <= to_cnt + 24'd1;
                    end
                end
                S_HOLDOFF: begin
                    if (ho_cnt == HO_LAST) begin
                        // A valid arriving on this edge sets its seen bit too, so it is not stranded in IDLE.
                        if (q_seen || g_seen || quat_valid || gyro_valid) begin
                            win_cnt <= '0;
                            st      <= S_COLLECT;
                        end else begin
                            st <= S_IDLE;
                        end
                    end else begin
                        ho_cnt <= ho_cnt + 1'b1;
                    end
                end
                default: st <= S_IDLE;
            endcase

            // Staging capture runs in every state. It comes last so a valid in the commit cycle overrides the seen-bit clear.
            if (quat_valid) begin
                stg_qw <= quat_w;
                stg_qx <= quat_x;
                stg_qy <= quat_y;
                stg_qz <= quat_z;
                q_seen <= 1'b1;
            end
            if (gyro_valid) begin
                stg_gx <= gyro_x;
                stg_gy <= gyro_y;
                stg_gz <= gyro_z;
                g_seen <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sensor_packet_scheduler.sv
// tb_sensor_packet_scheduler
// Directed vector table, hand-written corner sequences (freeze, timeout and
// saturation, asynchronous reset), then randomized traffic checked against a
// packet-level reference model built from sample queues.
`timescale 1ns/1ps
module tb_sensor_packet_scheduler;

    localparam int COLLECT_WIN = 64;
    localparam int ACK_TIMEOUT = 100;
    localparam int HOLDOFF_CYC = 40;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic               quat_valid = 1'b0;
    logic signed [15:0] quat_w = '0, quat_x = '0, quat_y = '0, quat_z = '0;
    logic               gyro_valid = 1'b0;
    logic signed [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
    logic               load = 1'b0;
    logic               done;
    logic signed [15:0] pkt_quat_w, pkt_quat_x, pkt_quat_y, pkt_quat_z;
    logic signed [15:0] pkt_gyro_x, pkt_gyro_y, pkt_gyro_z;
    logic [7:0]         pkt_flags;
    logic [7:0]         drop_cnt;
    logic [1:0]         state;

    sensor_packet_scheduler #(
        .COLLECT_WIN(COLLECT_WIN),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .HOLDOFF_CYC(HOLDOFF_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .quat_valid(quat_valid), .quat_w(quat_w), .quat_x(quat_x), .quat_y(quat_y), .quat_z(quat_z),
        .gyro_valid(gyro_valid), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
        .load(load), .done(done),
        .pkt_quat_w(pkt_quat_w), .pkt_quat_x(pkt_quat_x), .pkt_quat_y(pkt_quat_y), .pkt_quat_z(pkt_quat_z),
        .pkt_gyro_x(pkt_gyro_x), .pkt_gyro_y(pkt_gyro_y), .pkt_gyro_z(pkt_gyro_z),
        .pkt_flags(pkt_flags), .drop_cnt(drop_cnt), .state(state)
    );

    int tests = 0;
    int fails = 0;
    int exp_seq = 0;

    // ---------------- check helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [127:0] pkt_vec();
        return {pkt_quat_w, pkt_quat_x, pkt_quat_y, pkt_quat_z,
                pkt_gyro_x, pkt_gyro_y, pkt_gyro_z, pkt_flags, drop_cnt};
    endfunction

    function automatic logic [7:0] mk_flags(input logic [1:0] fl);
`ifdef PKT_SEQ_EN
        return {4'(exp_seq), 2'b00, fl};
`else
        return {6'b0, fl};
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 500) begin
            tick();
            n++;
        end
        check({tag, "_done"}, done, 1'b1);
    endtask

    task automatic do_ack(input string tag, input logic [1:0] exp_after);
        int k;
        int n;
        k = 0;
        n = 0;
        load = 1'b1;
        while (done && k < 20) begin
            tick();
            k++;
        end
        load = 1'b0;
        check_range({tag, "_ack_lat"}, k, 3, 4);
        while (state == 2'd3 && n < 2000) begin
            n++;
            tick();
        end
        check_range({tag, "_holdoff"}, n, HOLDOFF_CYC, HOLDOFF_CYC);
        check({tag, "_after_state"}, state, exp_after);
    endtask

    // ---------------- scoreboard / reference model (random phase) ----------------
    // Samples accepted since the last commit; the packet carries the newest of each.
    logic [63:0] quat_q[$];
    logic [47:0] gyro_q[$];
    logic        mon_en = 1'b0;
    logic        done_q = 1'b0;
    logic        prev_qv = 1'b0, prev_gv = 1'b0;
    logic [63:0] prev_q = '0;
    logic [47:0] prev_g = '0;
    logic [63:0] m_q = '0;
    logic [47:0] m_g = '0;
    logic [7:0]  m_flags = '0;
    logic [7:0]  m_drop = '0;
    int          m_seq = 0;
    int          hi_len = 0;
    int          lcnt = 0;
    logic        acked = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (done && !done_q) begin
                m_flags = {6'b0, (gyro_q.size() > 0), (quat_q.size() > 0)};
`ifdef PKT_SEQ_EN
                m_flags[7:4] = 4'(m_seq);
`endif
                if (quat_q.size() > 0) m_q = quat_q[$];
                if (gyro_q.size() > 0) m_g = gyro_q[$];
                quat_q.delete();
                gyro_q.delete();
                hi_len = 0;
                lcnt = 0;
                acked = 1'b0;
            end
            if (done) begin
                hi_len++;
                if (load) begin
                    acked = 1'b1;
                    lcnt++;
                end
            end else if (done_q) begin
                if (acked) begin
                    check_range("rand_ack_lat", lcnt, 3, 4);
                    m_seq++;
                end else begin
                    check_range("rand_timeout_len", hi_len, ACK_TIMEOUT, ACK_TIMEOUT);
                    if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                end
            end
            // Inputs consumed at the edge just passed belong after any commit on that edge.
            if (prev_qv) quat_q.push_back(prev_q);
            if (prev_gv) gyro_q.push_back(prev_g);
            check("rand_pkt", pkt_vec(), {m_q, m_g, m_flags, m_drop});
            done_q  = done;
            prev_qv = quat_valid;
            prev_q  = {quat_w, quat_x, quat_y, quat_z};
            prev_gv = gyro_valid;
            prev_g  = {gyro_x, gyro_y, gyro_z};
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        int          q_dly;
        int          g_dly;
        logic [15:0] qw;
        logic [15:0] gz;
        int          exp_lat;
        logic [1:0]  exp_fl;
        logic [15:0] exp_qw;
        logic [15:0] exp_gz;
    } vec_t;

    vec_t vecs[5];
    int   lat;
    int   hi;
    int   n;
    logic armed;
    int   dly;

    initial begin
        vecs[0] = '{0, 0, 16'h1234, 16'h8001, 2, 2'b11, 16'h1234, 16'h8001};
        vecs[1] = '{0, -1, 16'h1111, 16'h0000, COLLECT_WIN + 1, 2'b01, 16'h1111, 16'h8001};
        vecs[2] = '{-1, 0, 16'h0000, 16'h2222, COLLECT_WIN + 1, 2'b10, 16'h1111, 16'h2222};
        vecs[3] = '{0, 5, 16'h3333, 16'h4444, 7, 2'b11, 16'h3333, 16'h4444};
        vecs[4] = '{0, COLLECT_WIN - 1, 16'h5555, 16'h6666, COLLECT_WIN + 1, 2'b11, 16'h5555, 16'h6666};

        // Reset state, during and just after reset.
        repeat (3) @(posedge clk);
        #1;
        check("reset_pkt", pkt_vec(), 128'h0);
        check("reset_done", done, 1'b0);
        check("reset_state", state, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_reset_state", state, 2'd0);

        // Table-driven packets: latency, contents, flags, ack and holdoff.
        for (int i = 0; i < 5; i++) begin
            lat = -1;
            for (int c = 0; c < 200 && lat < 0; c++) begin
                tick();
                if (done) lat = c;
                quat_valid = (lat < 0 && c == vecs[i].q_dly);
                gyro_valid = (lat < 0 && c == vecs[i].g_dly);
                if (quat_valid) quat_w = vecs[i].qw;
                if (gyro_valid) gyro_z = vecs[i].gz;
            end
            quat_valid = 1'b0;
            gyro_valid = 1'b0;
            check_range($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_quat_w", i), $unsigned(pkt_quat_w), vecs[i].exp_qw);
            check($sformatf("vec%0d_gyro_z", i), $unsigned(pkt_gyro_z), vecs[i].exp_gz);
            check($sformatf("vec%0d_flags", i), pkt_flags, mk_flags(vecs[i].exp_fl));
            do_ack($sformatf("vec%0d", i), 2'd0);
            exp_seq++;
        end

        // Freeze: a sample during PRESENT must not disturb the snapshot and must become the next packet.
        quat_valid = 1'b1;
        quat_w = 16'h0AAA;
        gyro_valid = 1'b1;
        gyro_z = 16'h0BBB;
        tick();
        quat_valid = 1'b0;
        gyro_valid = 1'b0;
        wait_done("frz", lat);
        tick();
        quat_valid = 1'b1;
        quat_w = 16'h7FFF;
        tick();
        quat_valid = 1'b0;
        repeat (3) begin
            tick();
            check("frz_hold_quat_w", $unsigned(pkt_quat_w), 16'h0AAA);
        end
        check("frz_flags", pkt_flags, mk_flags(2'b11));
        do_ack("frz", 2'd1);
        exp_seq++;
        wait_done("frz2", lat);
        check_range("frz2_window", lat, COLLECT_WIN, COLLECT_WIN);
        check("frz2_quat_w", $unsigned(pkt_quat_w), 16'h7FFF);
        check("frz2_gyro_z_held", $unsigned(pkt_gyro_z), 16'h0BBB);
        check("frz2_flags", pkt_flags, mk_flags(2'b01));
        do_ack("frz2", 2'd0);
        exp_seq++;

        // Timeout and drop counter saturation; sequence number repeats across drops.
        for (int i = 0; i < 257; i++) begin
            n = 0;
            while (state != 2'd0 && n < 500) begin
                tick();
                n++;
            end
            quat_valid = 1'b1;
            quat_w = 16'(i);
            gyro_valid = 1'b1;
            tick();
            quat_valid = 1'b0;
            gyro_valid = 1'b0;
            wait_done("to", lat);
            check("to_flags", pkt_flags, mk_flags(2'b11));
            hi = 0;
            while (done && hi < 500) begin
                tick();
                hi++;
            end
            if (i == 0) check_range("to_done_len", hi, ACK_TIMEOUT, ACK_TIMEOUT);
            check("to_drop_cnt", drop_cnt, (i + 1 > 255) ? 8'd255 : 8'(i + 1));
        end

        // Asynchronous reset in the middle of PRESENT.
        n = 0;
        while (state != 2'd0 && n < 500) begin
            tick();
            n++;
        end
        quat_valid = 1'b1;
        quat_w = 16'h4321;
        gyro_valid = 1'b1;
        gyro_z = 16'h5678;
        tick();
        quat_valid = 1'b0;
        gyro_valid = 1'b0;
        wait_done("mid", lat);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_state", state, 2'd0);
        check("mid_rst_pkt", pkt_vec(), 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        repeat (80) begin
            tick();
            if (done) hi++;
        end
        check_range("mid_rst_no_handshake", hi, 0, 0);

        // Randomized traffic against the reference model.
        armed = 1'b0;
        dly = -1;
        tick();
        mon_en = 1'b1;
        for (int c = 0; c < 8000; c++) begin
            tick();
            quat_valid = ($urandom_range(0, 19) == 0);
            if (quat_valid) begin
                quat_w = 16'($urandom);
                quat_x = 16'($urandom);
                quat_y = 16'($urandom);
                quat_z = 16'($urandom);
            end
            gyro_valid = ($urandom_range(0, 19) == 0);
            if (gyro_valid) begin
                gyro_x = 16'($urandom);
                gyro_y = 16'($urandom);
                gyro_z = 16'($urandom);
            end
            if (!done) begin
                load = 1'b0;
                armed = 1'b0;
            end else if (!armed) begin
                armed = 1'b1;
                dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 60));
            end else if (dly == 0) begin
                load = 1'b1;
                dly = -1;
            end else if (dly > 0) begin
                dly--;
            end
        end
        quat_valid = 1'b0;
        gyro_valid = 1'b0;
        tick();
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
